// File: rtl/fpcvt_seq_ctrl.sv
// Sequential 12-bit two's-complement to 1/3/4 minifloat converter.
// One shared shift/round path: one normalising shift per cycle, round-half-up with saturation.
module fpcvt_seq_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [11:0] d,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        s,
   output logic [2:0]  e,
   output logic [3:0]  f,
   output logic [7:0]  conv_count
);

   typedef enum logic [2:0] {IDLE, ABS, NORM, ROUND, DONE} state_t;

   state_t      state;
   logic [11:0] d_reg;
   logic [11:0] mag;
   logic [2:0]  sh;
   logic        sign;

   logic [4:0]  sum;
   logic [2:0]  exp_val;

   // Rounding adder: the bit just below the 4-bit significand decides half-up.
   always_comb begin
      sum     = {1'b0, mag[10:7]} + {4'b0000, mag[6]};
      exp_val = 3'd7 - sh;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         d_reg      <= '0;
         mag        <= '0;
         sh         <= '0;
         sign       <= 1'b0;
         s          <= 1'b0;
         e          <= '0;
         f          <= '0;
         conv_count <= '0;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  d_reg    <= d;
                  in_ready <= 1'b0;
                  state    <= ABS;
               end
            end
            ABS: begin
               // -2048 has no positive 12-bit counterpart, so it clamps to the largest magnitude.
               sign <= d_reg[11];
               if (d_reg == 12'h800)
                  mag <= 12'h7FF;
               else if (d_reg[11])
                  mag <= -d_reg;
               else
                  mag <= d_reg;
               sh    <= '0;
               state <= NORM;
            end
            NORM: begin
               if (mag[10] || sh == 3'd7) begin
                  state <= ROUND;
               end else begin
                  mag <= mag << 1;
                  sh  <= sh + 3'd1;
               end
            end
            ROUND: begin
               s <= sign;
               if (!sum[4]) begin
                  f <= sum[3:0];
                  e <= exp_val;
               end else if (exp_val != 3'd7) begin
                  f <= 4'b1000;
                  e <= exp_val + 3'd1;
               end else begin
                  f <= 4'hF;
                  e <= 3'd7;
               end
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid  <= 1'b0;
                  in_ready   <= 1'b1;
                  conv_count <= conv_count + 8'd1;
                  state      <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/fpcvt_seq_ctrl.md
# fpcvt_seq_ctrl

Multi-cycle controller that sequences 12-bit two's-complement to 8-bit floating-point conversion (1 sign, 3-bit exponent, 4-bit significand) over one shared shift/round datapath. It accepts one sample per valid/ready handshake and normalises serially, one shift per cycle. It applies round-half-up with carry and saturation, then holds the result until the consumer accepts it. It sits between the switch/sample front end and the display/output stage of the converter design.

## Interface
- No parameters; widths are fixed at 12-bit input and 1/3/4 output.
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample present.
- in_ready  out  1  controller can accept; high only in IDLE.
- d  in  12  two's-complement sample; captured on in_valid && in_ready.
- out_valid  out  1  result registers hold a valid conversion.
- out_ready  in  1  consumer accepts the result.
- s  out  1  sign.
- e  out  3  exponent.
- f  out  4  significand.
- conv_count  out  8  completed-output handshakes, wraps modulo 256.

## Operation
- States: IDLE, ABS, NORM, ROUND, DONE.
- IDLE: in_ready=1. On in_valid: latch d, go to ABS.
- ABS: sign=d[11]. mag=d[11]?-d:d, 12 bits. d=0x800 saturates mag to 0x7FF. Clear shift counter sh[2:0]. Go to NORM.
- NORM: evaluated each cycle.
  - Stop when mag[10]=1 or sh=7; go to ROUND.
  - Otherwise mag<=mag<<1, sh<=sh+1, stay in NORM.
  - mag[11] is always 0 here.
- ROUND: sig=mag[10:7], x=mag[6], exp=7-sh, sum=sig+x (5 bits).
  - sum[4]=0: f=sum[3:0], e=exp.
  - sum[4]=1 and exp<7: f=4'b1000, e=exp+1.
  - sum[4]=1 and exp=7: saturate to e=7, f=15.
  - s=sign. Load s/e/f registers, go to DONE.
- DONE: out_valid=1; s/e/f held stable. On out_ready: conv_count+=1 and go to IDLE.
- No input is accepted while busy; in_valid is ignored outside IDLE.
- Zero input gives s=0, e=0, f=0. No negative-zero output: -0 is impossible.

## Timing
- Reset (async assert, any state): state=IDLE, in_ready=1, out_valid=0, s=0, e=0, f=0, conv_count=0, mag=0, sh=0.
  - An in-flight conversion is discarded.
  - Deassertion is used as-is; no extra cycle is required.
- Let n = number of NORM shifts, 0..7: n = leading zeros of mag minus 1, capped at 7.
- Latency: accept edge -> out_valid high after 4+n edges.
  - Minimum 4, for |d|>=1024.
  - Maximum 11, for |d|<16.
- Throughput: one sample per 5+n cycles with out_ready tied high; no back-to-back acceptance.
- out_ready low: DONE is held indefinitely and outputs stay stable. in_ready stays 0.
- in_ready rises the cycle after the out handshake.
- out_valid and in_ready are never high in the same cycle.
- conv_count wraps 255 -> 0 on the 256th handshake.
- All outputs are registered.

## Test plan
- Reset then d=0x000, out_ready=1 -> s=0, e=0, f=0 after 11 cycles; conv_count=1.
- d=0x1A6 (422) -> s=0, e=5, f=13 after 6 cycles.
- d=0x07D (125), rounding carry -> s=0, e=4, f=8. Then d=0x7FF -> e=7, f=15 via saturation at 4-cycle latency.
- d=0x800 -> s=1, e=7, f=15. d=0xFFF (-1) -> s=1, e=0, f=1.
- Backpressure: hold out_ready=0 for 20 cycles after DONE -> out_valid, s, e, f stable; in_ready=0; a pulsed in_valid is ignored.
- Reset mid-NORM with d=0x003 asserted for 1 cycle -> all outputs return to reset values immediately. Perform 256 conversions -> conv_count wraps to 0.
